draw_border_fx: RTL and testbench

- Parametrised successor to the static playfield border renderer. Outputs border pixel colour for any active-area size and border thickness.
- Border colour is programmable and updates only at frame boundaries, so there is no tearing.
- Adds a frame-synchronous flash sequencer, triggered by game logic (crash / round end), that blinks the border N times.
- Sits between the VGA timing generator and the pixel mux. Output is registered, latency 1.

---
 rtl/draw_border_fx_pkg.sv | 30 +++
 rtl/draw_border_fx_flash_fsm.sv | 102 ++++++++++
 rtl/draw_border_fx.sv | 105 ++++++++++
 tb/tb_draw_border_fx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_border_fx_pkg.sv
// Shared types and helpers for the border renderer.
//   rgb_t        packed {r,g,b} colour, 8 bits per channel
//   fx_state_t   flash sequencer states
//   range_check  half-open interval test lo <= v < hi, used for region decode
package draw_border_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        SOLID     = 2'd0,
        FLASH_OFF = 2'd1,
        FLASH_ON  = 2'd2
    } fx_state_t;

    localparam int   DEF_H_ACTIVE = 800;
    localparam int   DEF_V_ACTIVE = 600;
    localparam rgb_t RGB_WHITE    = 24'hFFFFFF;
    localparam rgb_t RGB_BLACK    = 24'h000000;

    function automatic logic range_check(input int unsigned v,
                                         input int unsigned lo,
                                         input int unsigned hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/draw_border_fx_flash_fsm.sv
// Frame-synchronous border flash sequencer.
// Ports:
//   clock, reset_n         pixel clock, async active-low reset
//   frame_start            one-cycle pulse per frame; all phase changes happen here
//   flash_req              one-cycle request, latched while idle
//   lit                    border shown at full colour
//   dim                    border in its off half-phase
//   flash_busy             request pending or flash running
//
// state     | meaning
// SOLID     | idle, border lit; a request waits for the next frame_start
// FLASH_OFF | off half-phase, FLASH_PERIOD frames
// FLASH_ON  | on half-phase, FLASH_PERIOD frames; ends a blink pair
module border_flash_fsm
    import draw_border_pkg::*;
#(
    parameter int FLASH_PERIOD = 15,
    parameter int FLASH_COUNT  = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic frame_start,
    input  logic flash_req,
    output logic lit,
    output logic dim,
    output logic flash_busy
);

    localparam int FW = $clog2(FLASH_PERIOD + 1);
    localparam int LW = $clog2(FLASH_COUNT + 1);

    fx_state_t         r_state, w_state_nx;
    logic [FW-1:0]     r_fcnt,  w_fcnt_nx;
    logic [LW-1:0]     r_left,  w_left_nx;
    logic              r_pend,  w_pend_nx;
    logic              w_phase_end;

    assign w_phase_end = frame_start && (r_fcnt == FW'(FLASH_PERIOD - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SOLID;
            r_fcnt  <= '0;
            r_left  <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_fcnt  <= w_fcnt_nx;
            r_left  <= w_left_nx;
            r_pend  <= w_pend_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_fcnt_nx  = r_fcnt;
        w_left_nx  = r_left;
        w_pend_nx  = r_pend;
        case (r_state)
            SOLID: begin
                // A request arriving on the frame_start cycle itself starts this frame.
                if (frame_start && (r_pend || flash_req)) begin
                    w_state_nx = FLASH_OFF;
                    w_fcnt_nx  = '0;
                    w_left_nx  = LW'(FLASH_COUNT);
                    w_pend_nx  = 1'b0;
                end else if (flash_req) begin
                    w_pend_nx = 1'b1;
                end
            end
            FLASH_OFF: begin
                if (w_phase_end) begin
                    w_fcnt_nx  = '0;
                    w_state_nx = FLASH_ON;
                end else if (frame_start) begin
                    w_fcnt_nx = r_fcnt + FW'(1);
                end
            end
            FLASH_ON: begin
                if (w_phase_end) begin
                    w_fcnt_nx = '0;
                    if (r_left == LW'(1)) begin
                        w_state_nx = SOLID;
                    end else begin
                        w_left_nx  = r_left - LW'(1);
                        w_state_nx = FLASH_OFF;
                    end
                end else if (frame_start) begin
                    w_fcnt_nx = r_fcnt + FW'(1);
                end
            end
            default: w_state_nx = SOLID;
        endcase
    end

    always_comb begin
        lit        = (r_state != FLASH_OFF);
        dim        = (r_state == FLASH_OFF);
        flash_busy = r_pend || (r_state != SOLID);
    end

endmodule

// File: rtl/draw_border_fx.sv
// Border pixel renderer with programmable colour and flash sequencer.
// Output is registered: row/col sampled at cycle t give red/green/blue/in_border at t+1.
// Ports:
//   clock, reset_n          pixel clock, async active-low reset
//   row, col                current pixel coordinate
//   frame_start             one-cycle pulse at start of frame
//   border_rgb              requested colour, latched only on frame_start
//   flash_req               one-cycle flash request
//   red, green, blue        pixel colour
//   in_border               pixel lies in the border region
//   flash_busy              flash pending or in progress
// Build option: DRAW_BORDER_FX_DIM_EN shows the border at quarter intensity
// during the off half-phase instead of black.
module draw_border_fx
    import draw_border_pkg::*;
#(
    parameter int CW           = 10,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int THICK        = 5,
    parameter int FLASH_PERIOD = 15,
    parameter int FLASH_COUNT  = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [CW-1:0] row,
    input  logic [CW-1:0] col,
    input  logic          frame_start,
    input  logic [23:0]   border_rgb,
    input  logic          flash_req,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue,
    output logic          in_border,
    output logic          flash_busy
);

    rgb_t        r_cur_rgb;
    rgb_t        w_pix;
    logic        w_border;
    logic        w_lit;
    logic        w_dim;
    int unsigned w_col;
    int unsigned w_row;

    border_flash_fsm #(
        .FLASH_PERIOD (FLASH_PERIOD),
        .FLASH_COUNT  (FLASH_COUNT)
    ) u_flash (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .flash_req   (flash_req),
        .lit         (w_lit),
        .dim         (w_dim),
        .flash_busy  (flash_busy)
    );

    assign w_col = 32'(col);
    assign w_row = 32'(row);

    // Border = inside the active area but outside the interior rectangle.
    assign w_border = range_check(w_col, 0, H_ACTIVE)
                   && range_check(w_row, 0, V_ACTIVE)
                   && !(range_check(w_col, THICK, H_ACTIVE - THICK)
                     && range_check(w_row, THICK, V_ACTIVE - THICK));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_rgb <= RGB_WHITE;
        end else if (frame_start) begin
            r_cur_rgb <= border_rgb;
        end
    end

    always_comb begin
        w_pix = RGB_BLACK;
        if (w_border && w_lit) begin
            w_pix = r_cur_rgb;
        end else if (w_border && w_dim) begin
`ifdef DRAW_BORDER_FX_DIM_EN
            w_pix.r = r_cur_rgb.r >> 2;
            w_pix.g = r_cur_rgb.g >> 2;
            w_pix.b = r_cur_rgb.b >> 2;
`else
            w_pix = RGB_BLACK;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            in_border <= 1'b0;
        end else begin
            red       <= w_pix.r;
            green     <= w_pix.g;
            blue      <= w_pix.b;
            in_border <= w_border;
        end
    end

endmodule

// File: tb/tb_draw_border_fx.sv
module tb_draw_border_fx;

    localparam int H = 800;
    localparam int V = 600;
    localparam int T = 5;
    localparam int P = 2;
    localparam int C = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  row = '0;
    logic [9:0]  col = '0;
    logic        frame_start = 1'b0;
    logic [23:0] border_rgb = 24'h123456;
    logic        flash_req = 1'b0;
    logic [7:0]  red, green, blue;
    logic        in_border, flash_busy;

    draw_border_fx #(
        .CW(10), .H_ACTIVE(H), .V_ACTIVE(V), .THICK(T),
        .FLASH_PERIOD(P), .FLASH_COUNT(C)
    ) dut (
        .clock(clock), .reset_n(reset_n), .row(row), .col(col),
        .frame_start(frame_start), .border_rgb(border_rgb), .flash_req(flash_req),
        .red(red), .green(green), .blue(blue),
        .in_border(in_border), .flash_busy(flash_busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: colour, pending flag, and frames elapsed since flash start
    logic [23:0] m_cur = 24'hFFFFFF;
    bit          m_pend = 0;
    bit          m_active = 0;
    int          m_k = 0;
    logic [23:0] exp_rgb;
    bit          exp_brd;
    bit          exp_busy;

    typedef struct {
        int          r;
        int          c;
        bit          brd;
        logic [23:0] rgb;
    } vec_t;
    vec_t vt[$];

    bit lit_tab  [1:9] = '{0, 0, 1, 1, 0, 0, 1, 1, 1};
    bit busy_tab [1:9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

    function automatic bit is_border(int r, int c);
        if (c >= H || r >= V) return 0;
        return (c < T) || (c >= H - T) || (r < T) || (r >= V - T);
    endfunction

    function automatic logic [23:0] dimmed(logic [23:0] x);
`ifdef DRAW_BORDER_FX_DIM_EN
        return {x[23:16] >> 2, x[15:8] >> 2, x[7:0] >> 2};
`else
        return 24'h0;
`endif
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t row=%0d col=%0d)",
                     nm, act, exp, $time, row, col);
        end
    endtask

    task automatic chk_model(string nm);
        chk({nm, "_rgb"},  {8'h0, red, green, blue}, {8'h0, exp_rgb});
        chk({nm, "_brd"},  {31'h0, in_border},       {31'h0, exp_brd});
        chk({nm, "_busy"}, {31'h0, flash_busy},      {31'h0, exp_busy});
    endtask

    // One clock: predict from current inputs and model state, advance model, sample after edge.
    task automatic cycle();
        bit lit;
        lit = !m_active || (((m_k / P) % 2) == 1);
        exp_brd = is_border(int'(row), int'(col));
        exp_rgb = !exp_brd ? 24'h0 : (lit ? m_cur : dimmed(m_cur));
        if (frame_start) begin
            if (m_active) begin
                m_k++;
                if (m_k == 2 * P * C) m_active = 0;
            end else if (m_pend || flash_req) begin
                m_active = 1;
                m_k = 0;
                m_pend = 0;
            end
            m_cur = border_rgb;
        end else if (flash_req && !m_active) begin
            m_pend = 1;
        end
        exp_busy = m_pend || m_active;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        frame_start = 0;
        flash_req = 0;
        @(negedge clock);
        #2;
        reset_n = 0;
        #1;
        chk("rst_async_rgb",  {8'h0, red, green, blue}, 32'h0);
        chk("rst_async_brd",  {31'h0, in_border},       32'h0);
        chk("rst_async_busy", {31'h0, flash_busy},      32'h0);
        repeat (2) @(posedge clock);
        m_cur = 24'hFFFFFF;
        m_pend = 0;
        m_active = 0;
        m_k = 0;
        @(negedge clock);
        reset_n = 1;
    endtask

    initial begin
        int sel;
        apply_reset();

        // static region / latency / out-of-range vectors, SOLID white
        vt.push_back('{300,    0, 1, 24'hFFFFFF});
        vt.push_back('{300,    4, 1, 24'hFFFFFF});
        vt.push_back('{300,    5, 0, 24'h000000});
        vt.push_back('{300,  794, 0, 24'h000000});
        vt.push_back('{300,  795, 1, 24'hFFFFFF});
        vt.push_back('{300,  799, 1, 24'hFFFFFF});
        vt.push_back('{ 10,    2, 1, 24'hFFFFFF});
        vt.push_back('{  0,  400, 1, 24'hFFFFFF});
        vt.push_back('{  4,  400, 1, 24'hFFFFFF});
        vt.push_back('{  5,  400, 0, 24'h000000});
        vt.push_back('{594,  400, 0, 24'h000000});
        vt.push_back('{595,  400, 1, 24'hFFFFFF});
        vt.push_back('{599,  400, 1, 24'hFFFFFF});
        vt.push_back('{300,  805, 0, 24'h000000});
        vt.push_back('{600,    2, 0, 24'h000000});
        vt.push_back('{1023, 1023, 0, 24'h000000});
        for (int i = 0; i < vt.size(); i++) begin
            row = 10'(vt[i].r);
            col = 10'(vt[i].c);
            cycle();
            chk("vec_rgb", {8'h0, red, green, blue}, {8'h0, vt[i].rgb});
            chk("vec_brd", {31'h0, in_border},       {31'h0, vt[i].brd});
            chk("vec_busy", {31'h0, flash_busy},     32'h0);
        end

        // full row sweep
        row = 300;
        for (int c = 0; c < H; c++) begin
            col = 10'(c);
            cycle();
            chk_model("sweep");
        end

        // colour latch: mid-frame change waits for frame_start
        col = 0;
        border_rgb = 24'hFF0000;
        cycle();
        chk("latch_mid", {8'h0, red, green, blue}, 32'h00FFFFFF);
        frame_start = 1;
        cycle();
        chk("latch_fs", {8'h0, red, green, blue}, 32'h00FFFFFF);
        frame_start = 0;
        cycle();
        chk("latch_new", {8'h0, red, green, blue}, 32'h00FF0000);

        // flash: request mid frame 0, frames 1..9 follow
        flash_req = 1;
        cycle();
        flash_req = 0;
        chk("req_busy", {31'h0, flash_busy}, 32'h1);
        for (int f = 1; f <= 9; f++) begin
            frame_start = 1;
            cycle();
            chk_model("flash_fs");
            frame_start = 0;
            for (int j = 0; j < 3; j++) begin
                col = (j == 0) ? 10'd0 : (j == 1) ? 10'd797 : 10'd400;
                flash_req = (f == 4 && j == 1);
                cycle();
                flash_req = 0;
                chk_model("flash_px");
                if (j != 2)
                    chk("flash_rgb", {8'h0, red, green, blue},
                        {8'h0, lit_tab[f] ? 24'hFF0000 : dimmed(24'hFF0000)});
                chk("flash_busy", {31'h0, flash_busy}, {31'h0, busy_tab[f]});
            end
        end

        // request coincident with frame_start, new colour on the same frame
        border_rgb = 24'hFC8040;
        col = 0;
        frame_start = 1;
        flash_req = 1;
        cycle();
        frame_start = 0;
        flash_req = 0;
        cycle();
        chk_model("coinc");
`ifdef DRAW_BORDER_FX_DIM_EN
        chk("coinc_rgb", {8'h0, red, green, blue}, 32'h003F2010);
`else
        chk("coinc_rgb", {8'h0, red, green, blue}, 32'h0);
`endif
        chk("coinc_busy", {31'h0, flash_busy}, 32'h1);

        // reset during FLASH_OFF, then SOLID white
        apply_reset();
        cycle();
        chk("post_rst_rgb",  {8'h0, red, green, blue}, 32'h00FFFFFF);
        chk("post_rst_busy", {31'h0, flash_busy},      32'h0);
        chk_model("post_rst");

        // randomized against the model
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 3);
            row = 10'($urandom_range(0, 620));
            case (sel)
                0: begin row = 10'($urandom_range(0, 1023)); col = 10'($urandom_range(0, 1023)); end
                1: col = 10'($urandom_range(0, 9));
                2: col = 10'($urandom_range(790, 809));
                default: begin
                    col = 10'($urandom_range(0, 820));
                    row = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 9))
                                                     : 10'($urandom_range(590, 609));
                end
            endcase
            frame_start = ($urandom_range(0, 7) == 0);
            flash_req   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) border_rgb = 24'($urandom);
            cycle();
            chk_model("rand");
        end
        frame_start = 0;
        flash_req = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
